freq_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter on the frequency counter's display path. It sits between the gated count register (`freq`) and the seven-segment digit scanner. It converts a latched 32-bit count into eight packed BCD digits using a multi-cycle shift-add-3 (double-dabble) datapath, so a wide combinational divider chain is not needed. A start/done handshake lets the gate logic launch one conversion per measurement window.

---
 rtl/freq_bcd_converter_if.sv | 23 ++
 rtl/freq_bcd_converter.sv | 90 +++++++++
 tb/tb_freq_bcd_converter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/freq_bcd_converter_if.sv
// Request/result bundle between the gate logic (master) and the binary-to-BCD converter (slave).
// The converter drives busy/done/bcd/overflow; the gate logic drives start and bin.
interface freq_bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/freq_bcd_converter.sv
// Multi-cycle double-dabble converter: latched WIDTH-bit count -> DIGITS packed BCD digits,
// saturating to all nines when the count does not fit. Result registers hold between conversions.
module freq_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input logic                 clock,
  input logic                 reset,
  freq_bcd_converter_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(pow10(DIGITS) - 64'd1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pending;

  // Add-3 correction for every digit, all taken from the pre-adjust scratch value.
  always_comb begin
    // NOTE: every always_comb output gets a full default before any conditional update, so no latch is inferred.
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scratch     <= '0;
      shreg       <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd     <= '0;
      bus.overflow <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shreg       <= bus.bin;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= (bus.bin > MAX_VAL);
            bus.busy    <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[BCD_W-2:0], shreg[WIDTH-1]};
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          // A set bit leaving the top digit only happens for values already flagged as overflow.
          ovf_pending <= ovf_pending | adj[BCD_W-1];
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          if (ovf_pending) begin
            bus.bcd      <= {DIGITS{4'h9}};
            bus.overflow <= 1'b1;
          end else begin
            bus.bcd      <= scratch;
            bus.overflow <= 1'b0;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_bcd_converter.sv
// Scoreboard bench for freq_bcd_converter: the driver queues expected results at each accepted
// start, a negedge monitor pops and compares on every done pulse and checks bcd hold while busy.
module tb_freq_bcd_converter;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;
  localparam int LAT    = WIDTH + 1;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t        q[$];
  logic [31:0] held_bcd = '0;
  logic        held_ovf = 1'b0;

  freq_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) cbus ();

  freq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (cbus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whenever the DUT presents a result; bcd must not move while busy.
  always @(negedge clock) begin
    if (!reset) begin
      if (cbus.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(cbus.bcd), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("bcd", 64'(cbus.bcd), 64'(e.bcd));
          check("overflow", 64'(cbus.overflow), 64'(e.ovf));
          check("latency", 64'(cyc - e.acc), 64'(LAT));
          check("busy_on_done", 64'(cbus.busy), 64'd0);
          held_bcd = e.bcd;
          held_ovf = e.ovf;
        end
      end else if (cbus.busy) begin
        check("bcd_hold", 64'({cbus.overflow, cbus.bcd}), 64'({held_ovf, held_bcd}));
      end
    end
  end

  // Issue one conversion once the DUT is idle; called and returns at a negedge.
  task automatic issue(input logic [31:0] b, input logic [31:0] e_bcd, input logic e_ovf);
    int t;
    exp_t e;
    t = 0;
    while (cbus.busy && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) check("idle_timeout", 64'(cbus.busy), 64'd0);
    cbus.start = 1'b1;
    cbus.bin   = b;
    @(negedge clock);
    cbus.start = 1'b0;
    check("busy_after_accept", 64'(cbus.busy), 64'd1);
    e.bcd = e_bcd;
    e.ovf = e_ovf;
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!cbus.done && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("done_seen", 64'(cbus.done), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || cbus.busy) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    cbus.start = 1'b0;
    cbus.bin   = '0;

    // Asynchronous reset with no clock edge yet.
    #1 reset = 1'b1;
    #1;
    check("rst_busy", 64'(cbus.busy), 64'd0);
    check("rst_done", 64'(cbus.done), 64'd0);
    check("rst_bcd", 64'(cbus.bcd), 64'd0);
    check("rst_ovf", 64'(cbus.overflow), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd0, 32'h0000_0000, 1'b0);
    drain();
    issue(32'd12345678, 32'h1234_5678, 1'b0);
    issue(32'd2500, 32'h0000_2500, 1'b0);
    issue(32'd99999999, 32'h9999_9999, 1'b0);
    issue(32'd100000000, 32'h9999_9999, 1'b1);
    issue(32'hFFFF_FFFF, 32'h9999_9999, 1'b1);
    drain();

    // start while busy is ignored, bin changes after acceptance have no effect.
    issue(32'd5, 32'h0000_0005, 1'b0);
    repeat (9) @(negedge clock);
    cbus.start = 1'b1;
    cbus.bin   = 32'd7;
    @(negedge clock);
    cbus.start = 1'b0;
    cbus.bin   = 32'hDEAD_BEEF;
    wait_done();
    // Back-to-back: start raised during the done cycle.
    issue(32'd42, 32'h0000_0042, 1'b0);
    drain();

    // Reset in the middle of a conversion.
    issue(32'd321, 32'h0000_0321, 1'b0);
    drain();
    issue(32'd999, 32'h0000_0999, 1'b0);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    q.delete();
    held_bcd = '0;
    held_ovf = 1'b0;
    check("midrst_busy", 64'(cbus.busy), 64'd0);
    check("midrst_done", 64'(cbus.done), 64'd0);
    check("midrst_bcd", 64'(cbus.bcd), 64'd0);
    check("midrst_ovf", 64'(cbus.overflow), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("post_rst_idle_bcd", 64'(cbus.bcd), 64'd0);
    issue(32'd88, 32'h0000_0088, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
